// File: rtl/div_ctrl.sv
// Purpose : sequences DIV/DIVU through an external iterative divider and writes HI/LO.
// Latency : request accepted in IDLE at T -> hilo_we at T+35 with the 33-cycle divider.
// Backpres: div_stall holds the EX request until DONE; a flushed op is drained before reuse.
// Option  : DIV_CTRL_ZERO_BYPASS_EN -- zero divisor skips the divider (hi=ex_a, lo=all ones, T+1).
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_req,
    input  logic        ex_div_sign,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        flush,
    output logic        div_stall,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] d_a,
    output logic [31:0] d_b,
    output logic        d_sign,
    output logic        d_opn_valid,
    output logic        d_res_ready,
    input  logic        d_res_valid,
    input  logic [63:0] d_result
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sign;
    logic        w_accept;
    logic        w_zero;
    logic        w_capture;

    // A request is only taken in IDLE and never in a flush cycle.
    assign w_accept  = (r_state == IDLE) && ex_div_req && !flush;
    // Result is kept only when it arrives in BUSY without a coincident flush.
    assign w_capture = (r_state == BUSY) && d_res_valid && !flush;

`ifdef DIV_CTRL_ZERO_BYPASS_EN
    assign w_zero = (ex_b == 32'd0);
`else
    assign w_zero = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Operand latch on accept; HI/LO update on divider result or zero bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_sign <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_a    <= ex_a;
                r_b    <= ex_b;
                r_sign <= ex_div_sign;
            end
            if (w_accept && w_zero) begin
                r_hi <= ex_a;
                r_lo <= 32'hFFFF_FFFF;
            end else if (w_capture) begin
                r_hi <= d_result[63:32];
                r_lo <= d_result[31:0];
            end
        end
    end

    // Next-state logic; ISSUE always hands the divider an operation, so a
    // flush from ISSUE onward must drain the result before the next issue.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = w_zero ? DONE : ISSUE;
            end
            ISSUE: begin
                w_next = flush ? DRAIN : BUSY;
            end
            BUSY: begin
                if (d_res_valid) w_next = flush ? IDLE : DONE;
                else if (flush)  w_next = DRAIN;
            end
            DONE: begin
                w_next = IDLE;
            end
            DRAIN: begin
                if (d_res_valid) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake and pipeline-control outputs, held low while in reset.
    always_comb begin
        d_opn_valid = 1'b0;
        d_res_ready = 1'b0;
        hilo_we     = 1'b0;
        div_stall   = 1'b0;
        if (!rst) begin
            d_opn_valid = (r_state == ISSUE);
            d_res_ready = (r_state == BUSY) || (r_state == DRAIN);
            hilo_we     = (r_state == DONE) && !flush;
            div_stall   = ex_div_req && !flush && (r_state != DONE);
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;
    assign d_a    = r_a;
    assign d_b    = r_b;
    assign d_sign = r_sign;

endmodule

// File: tb/tb_div_ctrl.sv
// Purpose : directed bench for div_ctrl with a 33-cycle divider model and HI/LO scoreboard.
// Latency : checks hilo_we timing against T+35 (or T+1 for the zero-divisor bypass build).
// Backpres: checks div_stall release cycle and that no operation is issued into a busy divider.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_req;
    logic        ex_div_sign;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        flush;
    logic        div_stall;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic        d_sign;
    logic        d_opn_valid;
    logic        d_res_ready;
    logic        d_res_valid;
    logic [63:0] d_result;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int opn_count = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          t;
    } exp_t;
    exp_t sb[$];

    div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ex_div_req  (ex_div_req),
        .ex_div_sign (ex_div_sign),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .flush       (flush),
        .div_stall   (div_stall),
        .hilo_we     (hilo_we),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .d_a         (d_a),
        .d_b         (d_b),
        .d_sign      (d_sign),
        .d_opn_valid (d_opn_valid),
        .d_res_ready (d_res_ready),
        .d_res_valid (d_res_valid),
        .d_result    (d_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Iterative divider model: result valid 33 cycles after the operand
    // handshake, held until consumed. Zero divisor returns {a, all ones}.
    int          m_cnt = 0;
    logic [63:0] m_res = 64'd0;

    function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic [31:0] q;
        logic [31:0] r;
        sa  = a;
        sbv = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            q = sa / sbv;
            r = sa % sbv;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
        end else if (d_opn_valid) begin
            m_cnt <= 33;
            m_res <= div_fn(d_a, d_b, d_sign);
            opn_count <= opn_count + 1;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1 && d_res_ready) begin
            m_cnt <= 0;
        end
    end

    assign d_res_valid = (m_cnt == 1);
    assign d_result    = m_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer and issue-safety monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (hilo_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_hilo_we", {32'd0, cyc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hi_out", {32'd0, hi_out}, {32'd0, e.hi});
                    chk("lo_out", {32'd0, lo_out}, {32'd0, e.lo});
                    chk("hilo_we_cycle", cyc, e.t);
                end
            end
            if (d_opn_valid) chk("opn_while_divider_busy", m_cnt, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, expect it to complete lat cycles after driving.
    task automatic do_req(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int lat,
                          input string tag);
        int t0;
        bit done;
        exp_t e;
        ex_div_req  = 1'b1;
        ex_div_sign = s;
        ex_a        = a;
        ex_b        = b;
        t0   = cyc;
        e.hi = hi;
        e.lo = lo;
        e.t  = t0 + lat;
        sb.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (lat > 1 && cyc == t0 + lat - 34) begin
                chk({tag, "_issue_valid"}, {63'd0, d_opn_valid}, 64'd1);
                chk({tag, "_d_a"}, {32'd0, d_a}, {32'd0, a});
                chk({tag, "_d_b"}, {32'd0, d_b}, {32'd0, b});
                chk({tag, "_d_sign"}, {63'd0, d_sign}, {63'd0, s});
            end
            if (!div_stall) done = 1'b1;
        end
        chk({tag, "_stall_released"}, {63'd0, done}, 64'd1);
        chk({tag, "_stall_low_cycle"}, cyc, t0 + lat);
        step();
        ex_div_req = 1'b0;
    endtask

    initial begin
        int t0;
        int opn_before;
        rst = 1'b1; ex_div_req = 1'b0; ex_div_sign = 1'b0;
        ex_a = 32'd0; ex_b = 32'd0; flush = 1'b0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_hi", {32'd0, hi_out}, 64'd0);
        chk("rst_lo", {32'd0, lo_out}, 64'd0);
        chk("rst_d_a", {32'd0, d_a}, 64'd0);
        chk("rst_d_b", {32'd0, d_b}, 64'd0);
        chk("rst_d_sign", {63'd0, d_sign}, 64'd0);
        chk("rst_opn", {63'd0, d_opn_valid}, 64'd0);
        chk("rst_ready", {63'd0, d_res_ready}, 64'd0);
        chk("rst_we", {63'd0, hilo_we}, 64'd0);
        chk("rst_stall", {63'd0, div_stall}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // DIVU 100/7
        do_req(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35, "divu_100_7");
        step();

        // Flush coincident with an IDLE request: ignored
        ex_div_req = 1'b1; ex_a = 32'hDEAD; ex_b = 32'd1; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", {63'd0, div_stall}, 64'd0);
        step();
        ex_div_req = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_opn", {63'd0, d_opn_valid}, 64'd0);
        chk("idle_flush_d_a", {32'd0, d_a}, 64'd100);
        step();

        // DIV -7/2
        do_req(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, "div_m7_2");

        // HI/LO hold between operations
        step(); step(); step();
        @(negedge clk);
        chk("hold_hi", {32'd0, hi_out}, 64'hFFFF_FFFF);
        chk("hold_lo", {32'd0, lo_out}, 64'hFFFF_FFFD);
        step();

        // Flush in BUSY at T+10, new DIVU 9/3 at T+11 waits for drain
        ex_div_req = 1'b1; ex_div_sign = 1'b0; ex_a = 32'd50; ex_b = 32'd5;
        t0 = cyc;
        while (cyc < t0 + 10) step();
        ex_div_req = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("drain_ready", {63'd0, d_res_ready}, 64'd1);
        do_req(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 59, "divu_9_3_after_drain");
        step();

        // Flush coincident with d_res_valid in BUSY
        ex_div_req = 1'b1; ex_div_sign = 1'b0; ex_a = 32'd77; ex_b = 32'd4;
        t0 = cyc;
        while (cyc < t0 + 34) step();
        ex_div_req = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("coinc_we", {63'd0, hilo_we}, 64'd0);
        chk("coinc_idle_ready", {63'd0, d_res_ready}, 64'd0);
        chk("coinc_consumed", m_cnt, 0);
        chk("coinc_hi_held", {32'd0, hi_out}, 64'd0);
        chk("coinc_lo_held", {32'd0, lo_out}, 64'd3);
        step();

        // Zero divisor: bypass or pass-through of the divider's result
        opn_before = opn_count;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
        do_req(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, "divu_5_0");
        step();
        chk("bypass_no_opn", opn_count, opn_before);
`else
        do_req(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 35, "divu_5_0");
        step();
        chk("zero_via_divider", opn_count, opn_before + 1);
`endif

        // Reset mid-operation at T+20, then a clean DIVU 100/7
        ex_div_req = 1'b1; ex_div_sign = 1'b1; ex_a = 32'd1000; ex_b = 32'd3;
        t0 = cyc;
        while (cyc < t0 + 20) step();
        rst = 1'b1; ex_div_req = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_hi", {32'd0, hi_out}, 64'd0);
        chk("midrst_lo", {32'd0, lo_out}, 64'd0);
        chk("midrst_d_a", {32'd0, d_a}, 64'd0);
        chk("midrst_d_sign", {63'd0, d_sign}, 64'd0);
        chk("midrst_ready", {63'd0, d_res_ready}, 64'd0);
        chk("midrst_opn", {63'd0, d_opn_valid}, 64'd0);
        step();
        do_req(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35, "divu_100_7_after_rst");
        step(); step();

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
